// File: rtl/pu_msp430_sync_handshake_tx.sv
// Launch side of a multi-bit clock-domain crossing: captures a word on send_i,
// holds it on the crossing bus and runs a 4-phase req/ack handshake against a synchronized ack.
module pu_msp430_sync_handshake_tx #(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          send_i,
  input  logic [DW-1:0] data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          drop_o,
  output logic          timeout_o,
  output logic          xfer_req_o,
  output logic [DW-1:0] xfer_data_o,
  input  logic          xfer_ack_i
);

  // A zero TIMEOUT still needs a legal (unused) counter width.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] ack_sync_reg;
  logic                   ack_s;
  logic [CW-1:0]          cnt_reg;
  logic                   abort_reg;
  logic [DW-1:0]          data_q_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   drop_reg;
  logic                   timeout_reg;
  logic                   req_reg;

  // Only the last stage of this chain is ever looked at; xfer_ack_i may be X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], xfer_ack_i};
    end
  end

  assign ack_s = ack_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      abort_reg   <= 1'b0;
      data_q_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      drop_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      req_reg     <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      drop_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (send_i) begin
            data_q_reg <= data_i;
            req_reg    <= 1'b1;
            cnt_reg    <= '0;
            abort_reg  <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= REQ;
          end
        end
        REQ: begin
          if (send_i) drop_reg <= 1'b1;
          // A synchronized ack beats a timeout landing on the same edge.
          if (ack_s) begin
            req_reg   <= 1'b0;
            state_reg <= REL;
          end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
            req_reg     <= 1'b0;
            abort_reg   <= 1'b1;
            timeout_reg <= 1'b1;
            state_reg   <= REL;
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        REL: begin
          if (send_i) drop_reg <= 1'b1;
          if (!ack_s) begin
            done_reg  <= ~abort_reg;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign drop_o      = drop_reg;
  assign timeout_o   = timeout_reg;
  assign xfer_req_o  = req_reg;
  assign xfer_data_o = data_q_reg;

endmodule

// File: tb/tb_pu_msp430_sync_handshake_tx.sv
// Directed bench for the CDC launch handshake: normal, drop, timeout, collision, reset, back-to-back.
module tb_pu_msp430_sync_handshake_tx;

  logic        clk;
  logic        rst_n;
  logic        send_i;
  logic [15:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic        drop_o;
  logic        timeout_o;
  logic        xfer_req_o;
  logic [15:0] xfer_data_o;
  logic        xfer_ack_i;

  int total;
  int bad;

  pu_msp430_sync_handshake_tx #(
    .DW(16),
    .SYNC_STAGES(2),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .send_i(send_i),
    .data_i(data_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .drop_o(drop_o),
    .timeout_o(timeout_o),
    .xfer_req_o(xfer_req_o),
    .xfer_data_o(xfer_data_o),
    .xfer_ack_i(xfer_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transfer with a remote that acks immediately; ends in the done_o cycle.
  task automatic run_xfer(input logic [15:0] d, input string tag);
    send_i = 1'b1;
    data_i = d;
    tick();
    send_i = 1'b0;
    chk({tag, "_req"}, xfer_req_o, 1);
    chk({tag, "_data"}, xfer_data_o, d);
    chk({tag, "_drop"}, drop_o, 0);
    xfer_ack_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!xfer_req_o) break;
    end
    chk({tag, "_req_fall"}, xfer_req_o, 0);
    xfer_ack_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_o) break;
    end
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_busy_low"}, busy_o, 0);
    chk({tag, "_no_tmo"}, timeout_o, 0);
    chk({tag, "_data_end"}, xfer_data_o, d);
  endtask

  initial begin
    total = 0;
    bad = 0;
    send_i = 1'b0;
    data_i = 16'h0;
    xfer_ack_i = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_req", xfer_req_o, 0);
    chk("rst_data", xfer_data_o, 0);
    chk("rst_pulses", {done_o, drop_o, timeout_o}, 0);
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();

    // Normal transfer with a drop attempt while busy
    send_i = 1'b1;
    data_i = 16'hA5C3;
    tick();                                  // E0
    chk("n_busy", busy_o, 1);
    chk("n_req", xfer_req_o, 1);
    chk("n_data", xfer_data_o, 16'hA5C3);
    data_i = 16'h1111;                       // send_i stays high: dropped at E1
    tick();                                  // E1
    send_i = 1'b0;
    chk("d_drop", drop_o, 1);
    chk("d_data", xfer_data_o, 16'hA5C3);
    tick();                                  // E2
    chk("d_drop_once", drop_o, 0);
    xfer_ack_i = 1'b1;
    tick();                                  // E3 sync1
    tick();                                  // E4 ack_s
    chk("n_req_hold", xfer_req_o, 1);
    tick();                                  // E5 release
    chk("n_req_fall", xfer_req_o, 0);
    chk("n_busy_rel", busy_o, 1);
    tick();                                  // E6
    tick();                                  // E7
    xfer_ack_i = 1'b0;
    tick();                                  // E8
    tick();                                  // E9 ack_s low
    chk("n_done_early", done_o, 0);
    chk("n_busy_wait", busy_o, 1);
    tick();                                  // E10
    chk("n_done", done_o, 1);
    chk("n_busy_low", busy_o, 0);
    chk("n_no_tmo", timeout_o, 0);
    chk("n_data_hold", xfer_data_o, 16'hA5C3);

    // Back-to-back: send in the done_o cycle
    run_xfer(16'hBEEF, "b2b");
    tick();
    chk("b2b_done_once", done_o, 0);

    // Timeout with ack held low
    send_i = 1'b1;
    data_i = 16'h1234;
    tick();                                  // E0
    send_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("t_req_e%0d", k), xfer_req_o, 1);
      chk($sformatf("t_tmo_e%0d", k), timeout_o, 0);
    end
    tick();                                  // E8
    chk("t_req_fall", xfer_req_o, 0);
    chk("t_tmo", timeout_o, 1);
    chk("t_busy_e8", busy_o, 1);
    tick();                                  // E9
    chk("t_busy_low", busy_o, 0);
    chk("t_no_done", done_o, 0);
    chk("t_tmo_once", timeout_o, 0);
    tick();
    chk("t_no_done_late", done_o, 0);

    // Ack seen synchronized on the same edge as cnt==7
    send_i = 1'b1;
    data_i = 16'h4242;
    tick();                                  // E0
    send_i = 1'b0;
    for (int k = 1; k <= 5; k++) tick();     // E1..E5
    xfer_ack_i = 1'b1;
    tick();                                  // E6 sync1
    tick();                                  // E7 ack_s
    chk("c_req_e7", xfer_req_o, 1);
    tick();                                  // E8 decision
    chk("c_req_fall", xfer_req_o, 0);
    chk("c_no_tmo", timeout_o, 0);
    xfer_ack_i = 1'b0;
    tick();                                  // E9
    tick();                                  // E10
    chk("c_busy", busy_o, 1);
    tick();                                  // E11
    chk("c_done", done_o, 1);
    chk("c_no_tmo_end", timeout_o, 0);

    // Asynchronous reset mid-handshake
    send_i = 1'b1;
    data_i = 16'h5A5A;
    tick();
    send_i = 1'b0;
    xfer_ack_i = 1'b1;
    tick();
    chk("r_pre_req", xfer_req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_req", xfer_req_o, 0);
    chk("r_busy", busy_o, 0);
    chk("r_data", xfer_data_o, 0);
    chk("r_pulses", {done_o, drop_o, timeout_o}, 0);
    xfer_ack_i = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick();
    run_xfer(16'h00FF, "r_new");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
